// File: rtl/prod_acc_pkg.sv
// Shared types and defaults for the product accumulator stage.
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 10;
  localparam int COUNT_DEF  = 4;

  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: zero-extends the product and adds it to the running sum.
// Wraps by default; clamps to all-ones with PROD_ACCUMULATOR_SAT_EN.
module acc_adder
  import prod_acc_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              cout
);

  logic [ACC_W:0] full;

  assign full = {1'b0, a} + (ACC_W+1)'(b);
  assign cout = full[ACC_W];

`ifdef PROD_ACCUMULATOR_SAT_EN
  assign sum = cout ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Sums COUNT multiplier products per batch and holds the result on a
// valid/ready output. PROD_ACCUMULATOR_SAT_EN adds saturation and ovf.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int COUNT  = COUNT_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PROD_ACCUMULATOR_SAT_EN
  output logic              ovf,
`endif
  output logic              busy
);

  localparam int CW = cnt_w(COUNT);

  state_t          state;
  state_t          nstate;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             take;
  logic             last;
  logic             clr;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign take      = in_ready & in_valid;
  assign last      = (cnt == CW'(COUNT - 1));
  assign clr       = (state == IDLE) & start;

  acc_adder #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_add (
    .a   (acc),
    .b   (prod),
    .sum (sum),
    .cout(carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (1'b1)
      (state == IDLE): if (start)       nstate = ACC;
      (state == ACC):  if (take && last) nstate = DONE;
      (state == DONE): if (out_ready)   nstate = IDLE;
      default:         nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= sum;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

`ifdef PROD_ACCUMULATOR_SAT_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (clr)  ovf_q <= 1'b0;
    else if (take) ovf_q <= ovf_q | carry;
  end

  assign ovf = ovf_q;
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench: a default 4-beat instance and an 8-beat instance.
module tb_prod_accumulator;

  logic       clk;
  logic       rst_n;
  logic       a_start, a_in_valid, a_in_ready;
  logic       a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_prod;
  logic [9:0] a_acc_out;
  logic       b_start, b_in_valid, b_in_ready;
  logic       b_out_valid, b_out_ready, b_busy;
  logic [7:0] b_prod;
  logic [9:0] b_acc_out;
`ifdef PROD_ACCUMULATOR_SAT_EN
  logic       a_ovf, b_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int qa[$];
  int qb[$];
  int part_a;

  prod_accumulator #(.PROD_W(8), .COUNT(4), .ACC_W(10)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (a_start),
    .prod     (a_prod),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .acc_out  (a_acc_out),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
`ifdef PROD_ACCUMULATOR_SAT_EN
    .ovf      (a_ovf),
`endif
    .busy     (a_busy)
  );

  prod_accumulator #(.PROD_W(8), .COUNT(8), .ACC_W(10)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (b_start),
    .prod     (b_prod),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .acc_out  (b_acc_out),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
`ifdef PROD_ACCUMULATOR_SAT_EN
    .ovf      (b_ovf),
`endif
    .busy     (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int a_obs();
`ifdef PROD_ACCUMULATOR_SAT_EN
    return (int'(a_ovf) << 16) | int'(a_acc_out);
`else
    return int'(a_acc_out);
`endif
  endfunction

  function automatic int b_obs();
`ifdef PROD_ACCUMULATOR_SAT_EN
    return (int'(b_ovf) << 16) | int'(b_acc_out);
`else
    return int'(b_acc_out);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_out", a_obs(), -1);
      else chk("a_result", a_obs(), qa.pop_front());
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_out", b_obs(), -1);
      else chk("b_result", b_obs(), qb.pop_front());
    end
  end

  task automatic pulse_start(input bit s);
    @(posedge clk); #1;
    if (s) b_start = 1'b1;
    else begin
      a_start = 1'b1;
      part_a  = 0;
    end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic send(input bit s, input int v, input int gap);
    int n;
    bit rdy;
    repeat (gap) begin
      @(negedge clk);
      if (!s) chk("a_stall_hold", int'(a_acc_out), part_a);
      @(posedge clk); #1;
    end
    if (s) begin
      b_prod = 8'(v); b_in_valid = 1'b1;
    end else begin
      a_prod = 8'(v); a_in_valid = 1'b1;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = s ? b_in_ready : a_in_ready;
      n++;
    end
    if (!rdy) chk("beat_accept_timeout", 0, 1);
    chk("busy_in_acc", int'(s ? b_busy : a_busy), 1);
    if (!s) begin
      chk("a_partial", int'(a_acc_out), part_a);
      part_a = part_a + v;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic drain(input bit s);
    int n;
    n = 0;
    while ((s ? qb.size() : qa.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((s ? qb.size() : qa.size()) != 0) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_in_valid = 0; a_out_ready = 0; a_prod = 0;
    b_start = 0; b_in_valid = 0; b_out_ready = 0; b_prod = 0;
    part_a = 0;
    #1;
    chk("rst_acc_out", int'(a_acc_out), 0);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_busy", int'(a_busy), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // back-to-back beats 15,70,0,13
    a_out_ready = 1'b1;
    qa.push_back(98);
    pulse_start(0);
    send(0, 15, 0);
    send(0, 70, 0);
    send(0, 0, 0);
    send(0, 13, 0);
    @(negedge clk);
    chk("t1_latency_valid", int'(a_out_valid), 1);
    chk("t1_busy_done", int'(a_busy), 1);
    @(negedge clk);
    chk("t1_idle_valid", int'(a_out_valid), 0);
    chk("t1_idle_busy", int'(a_busy), 0);
    drain(0);

    // gapped beats and back-pressure
    a_out_ready = 1'b0;
    pulse_start(0);
    send(0, 0, 2);
    send(0, 5, 2);
    send(0, 225, 2);
    send(0, 225, 2);
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", int'(a_out_valid), 1);
      chk("t2_hold_acc", int'(a_acc_out), 455);
      chk("t2_hold_inrdy", int'(a_in_ready), 0);
    end
    qa.push_back(455);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("t2_valid_drop", int'(a_out_valid), 0);
    drain(0);

    // start ignored in ACC and at the DONE handshake
    pulse_start(0);
    send(0, 1, 0);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    send(0, 2, 0);
    send(0, 3, 0);
    send(0, 4, 0);
    qa.push_back(10);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_start = 1'b0;
    a_in_valid = 1'b1;
    a_prod = 8'd7;
    repeat (3) begin
      @(negedge clk);
      chk("t3_idle_busy", int'(a_busy), 0);
      chk("t3_idle_inrdy", int'(a_in_ready), 0);
      chk("t3_idle_acc", int'(a_acc_out), 10);
    end
    a_in_valid = 1'b0;
    drain(0);

    // asynchronous reset mid-batch
    pulse_start(0);
    send(0, 1, 0);
    send(0, 2, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", int'(a_out_valid), 0);
    chk("t4_rst_inrdy", int'(a_in_ready), 0);
    chk("t4_rst_acc", int'(a_acc_out), 0);
    chk("t4_rst_busy", int'(a_busy), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    qa.push_back(10);
    pulse_start(0);
    send(0, 1, 0);
    send(0, 2, 0);
    send(0, 3, 0);
    send(0, 4, 0);
    drain(0);

    // eight beats of 225 on the 8-beat instance
    b_out_ready = 1'b1;
`ifdef PROD_ACCUMULATOR_SAT_EN
    qb.push_back((1 << 16) | 1023);
`else
    qb.push_back(776);
`endif
    pulse_start(1);
    for (int i = 0; i < 8; i++) send(1, 225, 0);
    drain(1);
    qb.push_back(8);
    pulse_start(1);
`ifdef PROD_ACCUMULATOR_SAT_EN
    @(negedge clk);
    chk("b_ovf_cleared", int'(b_ovf), 0);
`endif
    for (int i = 0; i < 8; i++) send(1, 1, 0);
    drain(1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
